// File: rtl/seg_scan_if.sv
// Bundle of the scan controller's control inputs and display outputs.
// The master drives the loading and enable side; the slave is the scan controller.
interface seg_scan_if #(
    parameter int DIGITS = 8
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   data_in;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank_lz;
    logic [3:0]            code;
    logic                  dp;
    logic [DIGITS-1:0]     sel;
    logic [2:0]            idx;

    modport master (
        output en, load, data_in, dp_in, blank_lz,
        input  code, dp, sel, idx
    );

    modport slave (
        input  en, load, data_in, dp_in, blank_lz,
        output code, dp, sel, idx
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one digit per slot, blank guard
// band at the start of each slot, optional leading-zero suppression.
module seg_scan_ctrl #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int DIGITS   = 8,
    parameter int GUARD    = 4
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);
    localparam int DIV = CLK_FREQ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;

    state_t                state_reg, state_next;
    logic [PW-1:0]         pc_reg, pc_next;
    logic [IW-1:0]         slot_reg, slot_next;
    logic [3:0]            code_reg, code_next;
    logic                  dp_reg, dp_next;
    logic [DIGITS-1:0]     sel_reg, sel_next;
    logic                  lit_reg, lit_next;
    logic [4*DIGITS-1:0]   shadow_data_reg;
    logic [DIGITS-1:0]     shadow_dp_reg;

    // A load coinciding with a slot boundary must feed the digit being entered.
    logic [4*DIGITS-1:0]   eff_data;
    logic [DIGITS-1:0]     eff_dp;
    logic [3:0]            nib [DIGITS];
    logic [DIGITS-1:0]     zero_from;
    logic [DIGITS-1:0]     suppress;

    assign eff_data = bus.load ? bus.data_in : shadow_data_reg;
    assign eff_dp   = bus.load ? bus.dp_in   : shadow_dp_reg;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi] = eff_data[4*gi +: 4];
            // zero_from[k]: nibbles k..DIGITS-1 are all zero
            if (gi == DIGITS - 1) begin : g_top
                assign zero_from[gi] = (nib[gi] == 4'h0);
            end else begin : g_chain
                assign zero_from[gi] = (nib[gi] == 4'h0) && zero_from[gi+1];
            end
            assign suppress[gi] = (gi != 0) && bus.blank_lz && zero_from[gi] && !eff_dp[gi];
        end
    endgenerate

    logic          enter;
    logic [IW-1:0] enter_slot;
    logic [DIGITS-1:0] sel_show;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        slot_next  = slot_reg;
        code_next  = code_reg;
        dp_next    = dp_reg;
        sel_next   = sel_reg;
        lit_next   = lit_reg;
        enter      = 1'b0;
        enter_slot = '0;
        sel_show   = '1;
        sel_show[slot_reg] = 1'b0;

        if (!bus.en) begin
            state_next = OFF;
            pc_next    = '0;
            slot_next  = '0;
            code_next  = 4'h0;
            dp_next    = 1'b1;
            sel_next   = '1;
            lit_next   = 1'b0;
        end else begin
            case (state_reg)
                OFF: begin
                    state_next = BLANK;
                    pc_next    = '0;
                    sel_next   = '1;
                    enter      = 1'b1;
                    enter_slot = '0;
                end
                BLANK: begin
                    pc_next  = pc_reg + 1'b1;
                    sel_next = '1;
                    if (pc_reg == PW'(GUARD - 1)) begin
                        state_next = SHOW;
                        sel_next   = lit_reg ? sel_show : '1;
                    end
                end
                SHOW: begin
                    if (pc_reg == PW'(DIV - 1)) begin
                        state_next = BLANK;
                        pc_next    = '0;
                        sel_next   = '1;
                        enter      = 1'b1;
                        enter_slot = (slot_reg == IW'(DIGITS - 1)) ? '0 : slot_reg + 1'b1;
                    end else begin
                        pc_next = pc_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = OFF;
                    pc_next    = '0;
                    sel_next   = '1;
                end
            endcase
        end

        // Digit content is latched only when a slot begins, never mid-slot.
        if (enter) begin
            slot_next = enter_slot;
            code_next = nib[enter_slot];
            dp_next   = ~eff_dp[enter_slot];
            lit_next  = ~suppress[enter_slot];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= OFF;
            pc_reg          <= '0;
            slot_reg        <= '0;
            code_reg        <= 4'h0;
            dp_reg          <= 1'b1;
            sel_reg         <= '1;
            lit_reg         <= 1'b0;
            shadow_data_reg <= '0;
            shadow_dp_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            slot_reg  <= slot_next;
            code_reg  <= code_next;
            dp_reg    <= dp_next;
            sel_reg   <= sel_next;
            lit_reg   <= lit_next;
            if (bus.load) begin
                shadow_data_reg <= bus.data_in;
                shadow_dp_reg   <= bus.dp_in;
            end
        end
    end

    assign bus.code = code_reg;
    assign bus.dp   = dp_reg;
    assign bus.sel  = sel_reg;
    assign bus.idx  = 3'(slot_reg);
endmodule
